// File: rtl/oclib_fpga_serial_port_if.sv
// oclib_fpga_serial_port_if: DNA-port serial lines plus the identifier program handshake
//   master: read, shift, din, program_valid, program_data out; dout, shift_count, drained, program_ready in
//   slave : mirror of master
interface oclib_fpga_serial_port_if #(
    parameter int SerialBits = 96
);
    logic                                 read;
    logic                                 shift;
    logic                                 din;
    logic                                 dout;
    logic [$clog2(SerialBits+3)-1:0]      shift_count;
    logic                                 drained;
    logic                                 program_valid;
    logic [SerialBits-1:0]                program_data;
    logic                                 program_ready;

    modport master (
        output read, shift, din, program_valid, program_data,
        input  dout, shift_count, drained, program_ready
    );

    modport slave (
        input  read, shift, din, program_valid, program_data,
        output dout, shift_count, drained, program_ready
    );
endinterface

// File: rtl/oclib_fpga_serial_port.sv
// oclib_fpga_serial_port: behavioural DNA_PORTE2 stand-in presenting {id, 2'b01} LSB first
//   clock, reset : rising-edge clock, synchronous active-high reset
//   port (slave) : read/shift/din in, dout/shift_count/drained out,
//                  program_valid/program_data in, program_ready out
//   OC_FPGA_SERIAL_PORT_PROGRAM_EN : enables the one-time identifier program handshake;
//                  when undefined the identifier is the constant SerialValue
module oclib_fpga_serial_port #(
    parameter int                    SerialBits  = 96,
    parameter logic [SerialBits-1:0] SerialValue = SerialBits'(96'h0123_4567_89AB_CDEF_0011_2233)
) (
    input logic                    clock,
    input logic                    reset,
    oclib_fpga_serial_port_if.slave port
);
    localparam int              CW   = $clog2(SerialBits + 3);
    localparam logic [CW-1:0]   FULL = CW'(SerialBits + 2);

    logic [SerialBits+1:0] shreg;
    logic [SerialBits-1:0] id_reg;
    logic [CW-1:0]         count;

`ifdef OC_FPGA_SERIAL_PORT_PROGRAM_EN
    logic id_locked;

    // A transfer only updates id_reg; the shift register picks it up at the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_reg    <= SerialValue;
            id_locked <= 1'b0;
        end else if (port.program_valid && !id_locked) begin
            id_reg    <= port.program_data;
            id_locked <= 1'b1;
        end
    end

    assign port.program_ready = !id_locked;
`else
    logic unused_program;

    assign id_reg             = SerialValue;
    assign port.program_ready = 1'b0;
    assign unused_program     = ^{port.program_valid, port.program_data};
`endif

    // Read wins over shift, so a read mid-frame restarts cleanly.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= {SerialValue, 2'b01};
            count <= '0;
        end else if (port.read) begin
            shreg <= {id_reg, 2'b01};
            count <= '0;
        end else if (port.shift) begin
            shreg <= {port.din, shreg[SerialBits+1:1]};
            count <= (count == FULL) ? count : count + 1'b1;
        end
    end

    assign port.dout        = shreg[0];
    assign port.shift_count = count;
    assign port.drained     = (count == FULL);
endmodule

// File: tb/tb_oclib_fpga_serial_port.sv
// tb_oclib_fpga_serial_port: directed self-checking bench, SerialBits=8, SerialValue=8'hA5
module tb_oclib_fpga_serial_port;
    localparam int SB = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Frames as seen on dout, bit i = i-th bit presented: {id, 2'b01}
    localparam logic [9:0] FRAME_A5 = 10'b1010010101;
    localparam logic [9:0] FRAME_3C = 10'b0011110001;

    oclib_fpga_serial_port_if #(.SerialBits(SB)) bus ();

    oclib_fpga_serial_port #(
        .SerialBits (SB),
        .SerialValue(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .port (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d);
        bus.read  = r;
        bus.shift = s;
        bus.din   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Read then 9 shifts of din=0, checking every bit presented on dout.
    task automatic read_frame(input string tag, input logic [9:0] frame);
        step(1'b1, 1'b0, 1'b0);
        check({tag, "_bit0"}, 16'(bus.dout), 16'(frame[0]));
        check({tag, "_cnt0"}, 16'(bus.shift_count), 16'd0);
        for (int i = 1; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("%s_bit%0d", tag, i), 16'(bus.dout), 16'(frame[i]));
        end
    endtask

    initial begin
        bus.read          = 1'b0;
        bus.shift         = 1'b0;
        bus.din           = 1'b0;
        bus.program_valid = 1'b0;
        bus.program_data  = '0;
        do_reset();

        check("rst_dout", 16'(bus.dout), 16'd1);
        check("rst_cnt", 16'(bus.shift_count), 16'd0);
        check("rst_drained", 16'(bus.drained), 16'd0);
`ifdef OC_FPGA_SERIAL_PORT_PROGRAM_EN
        check("rst_ready", 16'(bus.program_ready), 16'd1);
`else
        check("rst_ready", 16'(bus.program_ready), 16'd0);
`endif

        // Frame straight out of reset, no read needed
        for (int i = 1; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("rst_frame_bit%0d", i), 16'(bus.dout), 16'(FRAME_A5[i]));
            check($sformatf("rst_frame_cnt%0d", i), 16'(bus.shift_count), 16'(i));
        end
        check("drained_at9", 16'(bus.drained), 16'd0);
        step(1'b0, 1'b1, 1'b0);
        check("drained_at10", 16'(bus.drained), 16'd1);
        check("cnt_at10", 16'(bus.shift_count), 16'd10);
        check("dout_din_replay", 16'(bus.dout), 16'd0);

        // Idle holds everything
        repeat (4) step(1'b0, 1'b0, 1'b1);
        check("idle_cnt", 16'(bus.shift_count), 16'd10);
        check("idle_dout", 16'(bus.dout), 16'd0);

        // Drain with din=1, then saturate
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b1);
        check("ones_dout", 16'(bus.dout), 16'd1);
        check("ones_cnt", 16'(bus.shift_count), 16'd10);
        repeat (5) step(1'b0, 1'b1, 1'b1);
        check("sat_cnt", 16'(bus.shift_count), 16'd10);
        check("sat_drained", 16'(bus.drained), 16'd1);
        check("sat_dout", 16'(bus.dout), 16'd1);
        step(1'b1, 1'b0, 1'b0);
        check("reread_dout", 16'(bus.dout), 16'd1);
        check("reread_cnt", 16'(bus.shift_count), 16'd0);
        step(1'b0, 1'b1, 1'b1);
        check("reread_shift1", 16'(bus.dout), 16'd0);

        // Read + shift together mid-frame restarts without shifting
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("mid_cnt4", 16'(bus.shift_count), 16'd4);
        step(1'b1, 1'b1, 1'b0);
        check("rs_cnt", 16'(bus.shift_count), 16'd0);
        check("rs_dout", 16'(bus.dout), 16'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rs_bit2", 16'(bus.dout), 16'd1);
        check("rs_cnt2", 16'(bus.shift_count), 16'd2);

`ifdef OC_FPGA_SERIAL_PORT_PROGRAM_EN
        // Program 3C, then a second program is ignored
        bus.program_valid = 1'b1;
        bus.program_data  = 8'h3C;
        step(1'b0, 1'b0, 1'b0);
        bus.program_valid = 1'b0;
        check("prog_ready_drop", 16'(bus.program_ready), 16'd0);
        read_frame("prog3c", FRAME_3C);
        bus.program_valid = 1'b1;
        bus.program_data  = 8'hFF;
        step(1'b0, 1'b0, 1'b0);
        bus.program_valid = 1'b0;
        check("prog2_ready", 16'(bus.program_ready), 16'd0);
        read_frame("prog_ff_ignored", FRAME_3C);

        // Program in the same cycle as read: old id this frame, new id next
        do_reset();
        bus.program_valid = 1'b1;
        bus.program_data  = 8'h3C;
        step(1'b1, 1'b0, 1'b0);
        bus.program_valid = 1'b0;
        check("same_cyc_ready", 16'(bus.program_ready), 16'd0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("same_cyc_bit%0d", i), 16'(bus.dout), 16'(FRAME_A5[i]));
            step(1'b0, 1'b1, 1'b0);
        end
        read_frame("next_read_3c", FRAME_3C);

        do_reset();
        check("rst2_ready", 16'(bus.program_ready), 16'd1);
        read_frame("rst2_a5", FRAME_A5);
`else
        // Programming is absent: valid is ignored, reads always yield A5
        bus.program_valid = 1'b1;
        bus.program_data  = 8'h3C;
        step(1'b0, 1'b0, 1'b0);
        check("noprog_ready", 16'(bus.program_ready), 16'd0);
        read_frame("noprog_a5", FRAME_A5);
        check("noprog_ready2", 16'(bus.program_ready), 16'd0);
        read_frame("noprog_a5b", FRAME_A5);
        bus.program_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
